ex_mem_elastic_pipeline: RTL
============================

// Module: ex_mem_elastic_pipeline
// PURPOSE
//  Parametrised EX->MEM stage register with a valid/ready handshake and a 2-entry skid buffer.
//  Lets the MEM stage stall the EX stage, for example on a multi-cycle data-memory access, without losing an instruction.
//  Adds flush (bubble insertion) and a saturating stall-cycle counter.
//  Sits between the ALU/branch logic and the data-memory stage.
// PARAMETERS
//  XLEN        32  width of PC, ALU result and store data
//  RA_W        5   register-file write-address width
//  MRD_W       4   data-memory read-control width
//  MWR_W       3   data-memory write-control width
//  WBS_W       2   write-back value-select width
//  STALL_CNT_W 16  width of the stall-cycle counter
// PORTS
//  CLK                 in   1      clock, rising edge
//  RESET               in   1      reset, synchronous, active-high
//  FLUSH               in   1      discard all buffered instructions
//  EX_VALID            in   1      EX presents an instruction
//  EX_READY            out  1      stage can accept an instruction this cycle
//  EX_PC               in   XLEN   instruction PC
//  EX_ALU_OUT          in   XLEN   ALU result / memory address
//  EX_REG_DATA2        in   XLEN   store data
//  EX_REG_WRITE_ADDR   in   RA_W   destination register
//  EX_REG_WRITE_EN     in   1      register write enable
//  EX_DATA_MEM_WRITE   in   MWR_W  memory write control
//  EX_DATA_MEM_READ    in   MRD_W  memory read control
//  EX_WB_VALUE_SELECT  in   WBS_W  write-back mux select
//  MEM_VALID           out  1      MEM_* outputs hold a live instruction
//  MEM_READY           in   1      MEM stage consumes the instruction this cycle
//  MEM_PC .. MEM_WB_VALUE_SELECT  out  (as EX_*)  registered copies of the EX_* fields
//  STALL_CYCLES        out  STALL_CNT_W  cycles with MEM_VALID & ~MEM_READY, saturating
// BEHAVIOUR
//  - Handshakes:
//    - in_fire  = EX_VALID & EX_READY.
//    - out_fire = MEM_VALID & MEM_READY.
//  - Storage: main register drives MEM_*; skid register holds one overflow entry.
//  - States:
//    - EMPTY (main invalid)
//    - BUSY  (main valid, skid empty)
//    - FULL  (main and skid valid)
//  - Transitions:
//    - EMPTY: in_fire -> load main, go to BUSY.
//    - BUSY:
//      - in_fire & out_fire -> load main, stay BUSY.
//      - in_fire only -> load skid, go to FULL.
//      - out_fire only -> EMPTY.
//    - FULL: out_fire -> main <= skid, go to BUSY; otherwise hold.
//  - EX_READY = (state != FULL).
//    - Decoded from state registers only: no combinational path from MEM_READY.
//  - Timing:
//    - Latency 1 cycle from in_fire to MEM_VALID when unstalled.
//    - Throughput 1 instruction/cycle.
//    - Strict in-order delivery; no drops, no duplicates.
//  - Bubble rule: while MEM_VALID=0, MEM_REG_WRITE_EN, MEM_DATA_MEM_WRITE and MEM_DATA_MEM_READ read 0.
//    - The remaining data fields hold their last value.
//  - MEM_* stay stable while MEM_VALID & ~MEM_READY.
//  - RESET (highest priority):
//    - state EMPTY; all MEM_* outputs and skid contents 0; MEM_VALID=0; STALL_CYCLES=0.
//    - EX_READY=1 from the first cycle after RESET deasserts.
//    - Inputs sampled during RESET are ignored.
//  - FLUSH (below RESET):
//    - next state EMPTY; both entries invalidated; control outputs read 0.
//    - An in_fire in the same cycle is discarded.
//    - STALL_CYCLES is not cleared.
//    - Flush during FULL drops both entries.
//  - STALL_CYCLES:
//    - +1 per cycle with MEM_VALID & ~MEM_READY & ~FLUSH.
//    - Holds at 2^STALL_CNT_W-1; never wraps.
//  - MEM_READY is don't-care when MEM_VALID=0.
//  - EX_VALID with EX_READY=0: EX must hold its fields; the block does not sample them.
// STRUCTURE
//  - Shared package ex_mem_pkg:
//    - field-width localparams and the bundle width (sum of fields)
//    - state encoding EMPTY=2'b00, BUSY=2'b01, FULL=2'b10
//    - pack/unpack field offsets
//  - Sub-module pipe_skid_buffer #(WIDTH):
//    - generic packed-vector 2-entry elastic buffer with FLUSH.
//  - This wrapper:
//    - packs/unpacks the fields
//    - applies bubble masking of control outputs
//    - owns the stall counter
// TESTING
//  - Reset: RESET=1 for 2 cycles with EX_VALID=1 -> MEM_VALID=0, all MEM_*=0, STALL_CYCLES=0, EX_READY=1 after release.
//  - Streaming: MEM_READY=1, 8 back-to-back instructions PC=0x00..0x1C -> each appears one cycle later, in order, no gaps.
//  - Back-pressure:
//    - Stimulus: MEM_READY=0 for 3 cycles while PC=0x40,0x44,0x48 are offered.
//    - Response: EX_READY falls after 2 accepts; 0x48 is held by EX.
//    - Response: MEM_PC holds 0x40; STALL_CYCLES=3; on release 0x40,0x44,0x48 delivered in order.
//  - Flush in FULL:
//    - Stimulus: FLUSH=1 with both entries valid and EX_VALID=1 (PC=0x80).
//    - Response: next cycle MEM_VALID=0, MEM_REG_WRITE_EN=0, MEM_DATA_MEM_WRITE=0, MEM_DATA_MEM_READ=0.
//    - Response: 0x80 is never delivered.
//  - Saturation: STALL_CNT_W=4, stall 20 cycles -> STALL_CYCLES=15 and stays 15.
//  - Widths: XLEN=64, random valid/ready over 10k cycles -> scoreboard shows in-order, lossless delivery.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX->MEM elastic stage: default field widths,
// skid-buffer state encoding and the bundle field layout.
package ex_mem_pkg;

    localparam int XLEN_DEF        = 32;
    localparam int RA_W_DEF        = 5;
    localparam int MRD_W_DEF       = 4;
    localparam int MWR_W_DEF       = 3;
    localparam int WBS_W_DEF       = 2;
    localparam int STALL_CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } skid_state_e;

    // Bundle fields listed from LSB upwards; F_END yields the total width.
    typedef enum int {
        F_WBS, F_MRD, F_MWR, F_WE, F_WA, F_RD2, F_ALU, F_PC, F_END
    } field_e;

    function automatic int field_lsb(field_e f, int xlen, int ra_w,
                                     int mrd_w, int mwr_w, int wbs_w);
        int lsb;
        lsb = 0;
        for (int i = 0; i < int'(f); i++) begin
            case (i)
                0:       lsb += wbs_w;
                1:       lsb += mrd_w;
                2:       lsb += mwr_w;
                3:       lsb += 1;
                4:       lsb += ra_w;
                default: lsb += xlen;
            endcase
        end
        return lsb;
    endfunction

endpackage

// File: rtl/ex_mem_elastic_pipeline_skid.sv
// Generic 2-entry elastic buffer: main register feeds the output, skid
// register absorbs the one extra word accepted while the output stalls.
//
//   state | meaning
//   EMPTY | main invalid, skid invalid
//   BUSY  | main valid, skid invalid
//   FULL  | main valid, skid valid (in_ready low)
module pipe_skid_buffer
    import ex_mem_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             in_fire, out_fire;
    logic             load_main_in, load_main_skid, load_skid;

    // Ready is decoded from state only, so out_ready never reaches in_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_d        = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (FLUSH) begin
            state_d        = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/ex_mem_elastic_pipeline.sv
// EX->MEM stage register with valid/ready handshake, flush, bubble masking of
// memory/register-write controls and a saturating stall-cycle counter.
module ex_mem_elastic_pipeline
    import ex_mem_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int RA_W        = RA_W_DEF,
    parameter int MRD_W       = MRD_W_DEF,
    parameter int MWR_W       = MWR_W_DEF,
    parameter int WBS_W       = WBS_W_DEF,
    parameter int STALL_CNT_W = STALL_CNT_W_DEF
)(
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   FLUSH,
    input  logic                   EX_VALID,
    output logic                   EX_READY,
    input  logic [XLEN-1:0]        EX_PC,
    input  logic [XLEN-1:0]        EX_ALU_OUT,
    input  logic [XLEN-1:0]        EX_REG_DATA2,
    input  logic [RA_W-1:0]        EX_REG_WRITE_ADDR,
    input  logic                   EX_REG_WRITE_EN,
    input  logic [MWR_W-1:0]       EX_DATA_MEM_WRITE,
    input  logic [MRD_W-1:0]       EX_DATA_MEM_READ,
    input  logic [WBS_W-1:0]       EX_WB_VALUE_SELECT,
    output logic                   MEM_VALID,
    input  logic                   MEM_READY,
    output logic [XLEN-1:0]        MEM_PC,
    output logic [XLEN-1:0]        MEM_ALU_OUT,
    output logic [XLEN-1:0]        MEM_REG_DATA2,
    output logic [RA_W-1:0]        MEM_REG_WRITE_ADDR,
    output logic                   MEM_REG_WRITE_EN,
    output logic [MWR_W-1:0]       MEM_DATA_MEM_WRITE,
    output logic [MRD_W-1:0]       MEM_DATA_MEM_READ,
    output logic [WBS_W-1:0]       MEM_WB_VALUE_SELECT,
    output logic [STALL_CNT_W-1:0] STALL_CYCLES
);

    localparam int L_WBS    = field_lsb(F_WBS, XLEN, RA_W, MRD_W, MWR_W, WBS_W);
    localparam int L_MRD    = field_lsb(F_MRD, XLEN, RA_W, MRD_W, MWR_W, WBS_W);
    localparam int L_MWR    = field_lsb(F_MWR, XLEN, RA_W, MRD_W, MWR_W, WBS_W);
    localparam int L_WE     = field_lsb(F_WE,  XLEN, RA_W, MRD_W, MWR_W, WBS_W);
    localparam int L_WA     = field_lsb(F_WA,  XLEN, RA_W, MRD_W, MWR_W, WBS_W);
    localparam int L_RD2    = field_lsb(F_RD2, XLEN, RA_W, MRD_W, MWR_W, WBS_W);
    localparam int L_ALU    = field_lsb(F_ALU, XLEN, RA_W, MRD_W, MWR_W, WBS_W);
    localparam int L_PC     = field_lsb(F_PC,  XLEN, RA_W, MRD_W, MWR_W, WBS_W);
    localparam int BUNDLE_W = field_lsb(F_END, XLEN, RA_W, MRD_W, MWR_W, WBS_W);

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    logic [BUNDLE_W-1:0]    ex_bundle, mem_bundle;
    logic [STALL_CNT_W-1:0] stall_q;

    assign ex_bundle = {EX_PC, EX_ALU_OUT, EX_REG_DATA2, EX_REG_WRITE_ADDR,
                        EX_REG_WRITE_EN, EX_DATA_MEM_WRITE, EX_DATA_MEM_READ,
                        EX_WB_VALUE_SELECT};

    pipe_skid_buffer #(.WIDTH(BUNDLE_W)) u_skid (
        .CLK       (CLK),
        .RESET     (RESET),
        .FLUSH     (FLUSH),
        .in_valid  (EX_VALID),
        .in_ready  (EX_READY),
        .in_data   (ex_bundle),
        .out_valid (MEM_VALID),
        .out_ready (MEM_READY),
        .out_data  (mem_bundle)
    );

    // Side-effecting controls are forced low on bubbles; data fields keep their last value.
    assign MEM_PC              = mem_bundle[L_PC  +: XLEN];
    assign MEM_ALU_OUT         = mem_bundle[L_ALU +: XLEN];
    assign MEM_REG_DATA2       = mem_bundle[L_RD2 +: XLEN];
    assign MEM_REG_WRITE_ADDR  = mem_bundle[L_WA  +: RA_W];
    assign MEM_REG_WRITE_EN    = mem_bundle[L_WE] & MEM_VALID;
    assign MEM_DATA_MEM_WRITE  = mem_bundle[L_MWR +: MWR_W] & {MWR_W{MEM_VALID}};
    assign MEM_DATA_MEM_READ   = mem_bundle[L_MRD +: MRD_W] & {MRD_W{MEM_VALID}};
    assign MEM_WB_VALUE_SELECT = mem_bundle[L_WBS +: WBS_W];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_q <= '0;
        end else if (MEM_VALID && !MEM_READY && !FLUSH && stall_q != STALL_MAX) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign STALL_CYCLES = stall_q;

endmodule
